// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
//  Module   : operand_stack
//  Brief    : LIFO operand stack for a stack CPU datapath. DEPTH x WIDTH
//             register storage, registered read port, occupancy count,
//             full/empty status and sticky overflow/underflow flags.
//             Optional high-water mark output: define OPERAND_STACK_HWM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         tos_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         clr_err_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         ovf_o,
    output logic                         unf_o
`ifdef OPERAND_STACK_HWM_EN
   ,output logic [$clog2(DEPTH):0]       hwm_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   c_FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] c_IDX_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;

    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_top_idx;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_waddr;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == c_FULL_CNT);
    // Low AW bits of count minus one wraps to DEPTH-1 when the stack is full,
    // which is exactly the top slot; unused when empty.
    assign w_top_idx = count_q[AW-1:0] - c_IDX_ONE;

    // Command decode: next count/dout/flags and the single storage write.
    always_comb begin
        count_d     = count_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        w_mem_we    = 1'b0;
        w_mem_waddr = count_q[AW-1:0];

        // Clear first so that an error in the same cycle wins.
        if (clr_err_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        if (pop_i) begin
            // pop dominates tos
            if (!w_empty) begin
                dout_d = mem_q[w_top_idx];
                if (push_i) begin
                    // replace: old top captured into dout, new value overwrites it
                    w_mem_we    = 1'b1;
                    w_mem_waddr = w_top_idx;
                end else begin
                    count_d = count_q - c_CNT_ONE;
                end
            end else begin
                unf_d = 1'b1;
                if (push_i) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = '0;
                    count_d     = c_CNT_ONE;
                end
            end
        end else begin
            // tos looks at the pre-push top
            if (tos_i) begin
                if (!w_empty) begin
                    dout_d = mem_q[w_top_idx];
                end else begin
                    unf_d = 1'b1;
                end
            end
            if (push_i) begin
                if (!w_full) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = count_q[AW-1:0];
                    count_d     = count_q + c_CNT_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Control/status registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= din_i;
        end
    end

`ifdef OPERAND_STACK_HWM_EN
    logic [AW:0] hwm_q, hwm_d;

    assign hwm_d = (count_d > hwm_q) ? count_d : hwm_q;

    // High-water mark tracks the largest occupancy since reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`endif

    assign dout_o  = dout_q;
    assign count_o = count_q;
    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_stack
//  Brief    : Self-checking bench for operand_stack (WIDTH=8, DEPTH=4):
//             directed scenarios followed by random commands, compared
//             against a queue-based reference model of the stack.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk_i;
    logic             rst_ni;
    logic             push_i, pop_i, tos_i, clr_err_i;
    logic [WIDTH-1:0] din_i;
    logic [WIDTH-1:0] dout_o;
    logic             empty_o, full_o, ovf_o, unf_o;
    logic [2:0]       count_o;
`ifdef OPERAND_STACK_HWM_EN
    logic [2:0]       hwm_o;
`endif

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push_i),
        .pop_i     (pop_i),
        .tos_i     (tos_i),
        .din_i     (din_i),
        .clr_err_i (clr_err_i),
        .dout_o    (dout_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .count_o   (count_o),
        .ovf_o     (ovf_o),
        .unf_o     (unf_o)
`ifdef OPERAND_STACK_HWM_EN
       ,.hwm_o     (hwm_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue whose back is the top of the stack.
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_dout;
    bit               m_ovf, m_unf;
    int               m_hwm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":count"}, 32'(count_o), 32'(m_q.size()));
        chk({tag, ":empty"}, 32'(empty_o), 32'(m_q.size() == 0));
        chk({tag, ":full"},  32'(full_o),  32'(m_q.size() == DEPTH));
        chk({tag, ":dout"},  32'(dout_o),  32'(m_dout));
        chk({tag, ":ovf"},   32'(ovf_o),   32'(m_ovf));
        chk({tag, ":unf"},   32'(unf_o),   32'(m_unf));
`ifdef OPERAND_STACK_HWM_EN
        chk({tag, ":hwm"},   32'(hwm_o),   32'(m_hwm));
`endif
    endtask

    // Apply one command across one rising edge, update the model, then check.
    task automatic step(input string tag, input bit p, input bit po, input bit t,
                        input logic [WIDTH-1:0] d, input bit c);
        bit was_empty;
        push_i = p; pop_i = po; tos_i = t; din_i = d; clr_err_i = c;
        @(posedge clk_i);
        was_empty = (m_q.size() == 0);
        if (c) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (po) begin
            if (!was_empty) begin
                m_dout = m_q[$];
                if (p) m_q[$] = d;
                else   void'(m_q.pop_back());
            end else begin
                m_unf = 1;
                if (p) m_q.push_back(d);
            end
        end else begin
            if (t) begin
                if (!was_empty) m_dout = m_q[$];
                else            m_unf = 1;
            end
            if (p) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else                    m_ovf = 1;
            end
        end
        if (m_q.size() > m_hwm) m_hwm = m_q.size();
        #1;
        push_i = 0; pop_i = 0; tos_i = 0; clr_err_i = 0;
        check_all(tag);
    endtask

    // Assert reset asynchronously mid-cycle and check without any clock edge.
    task automatic do_reset(input string tag);
        push_i = 0; pop_i = 0; tos_i = 0; clr_err_i = 0;
        #2;
        rst_ni = 1'b0;
        #1;
        m_q.delete();
        m_dout = '0;
        m_ovf  = 0;
        m_unf  = 0;
        m_hwm  = 0;
        check_all(tag);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        push_i = 0; pop_i = 0; tos_i = 0; clr_err_i = 0; din_i = '0;
        m_dout = '0; m_ovf = 0; m_unf = 0; m_hwm = 0;
        rst_ni = 1'b0;
        #1;
        check_all("por");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Load something, then reset mid-cycle.
        step("pre1", 1, 0, 0, 8'hA1, 0);
        step("pre2", 1, 0, 0, 8'hA2, 0);
        step("pre3", 0, 1, 0, 8'h00, 0);
        step("pre4", 0, 1, 0, 8'h00, 0);
        step("pre5", 0, 1, 0, 8'h00, 0);
        do_reset("rst_mid");
        step("idle", 0, 0, 0, 8'h00, 0);

        // Fill and drain.
        step("fill1", 1, 0, 0, 8'h11, 0);
        step("fill2", 1, 0, 0, 8'h22, 0);
        step("fill3", 1, 0, 0, 8'h33, 0);
        step("fill4", 1, 0, 0, 8'h44, 0);
        chk("fill_full", 32'(full_o), 32'd1);
        step("drain1", 0, 1, 0, 8'h00, 0);
        chk("drain1_val", 32'(dout_o), 32'h44);
        step("drain2", 0, 1, 0, 8'h00, 0);
        chk("drain2_val", 32'(dout_o), 32'h33);
        step("drain3", 0, 1, 0, 8'h00, 0);
        chk("drain3_val", 32'(dout_o), 32'h22);
        step("drain4", 0, 1, 0, 8'h00, 0);
        chk("drain4_val", 32'(dout_o), 32'h11);
        chk("drain_empty", 32'(empty_o), 32'd1);

        // Overflow.
        step("ofill1", 1, 0, 0, 8'h11, 0);
        step("ofill2", 1, 0, 0, 8'h22, 0);
        step("ofill3", 1, 0, 0, 8'h33, 0);
        step("ofill4", 1, 0, 0, 8'h44, 0);
        step("ovf_push", 1, 0, 0, 8'h55, 0);
        chk("ovf_flag", 32'(ovf_o), 32'd1);
        chk("ovf_count", 32'(count_o), 32'd4);
        step("ovf_pop", 0, 1, 0, 8'h00, 0);
        chk("ovf_pop_val", 32'(dout_o), 32'h44);
        step("ovf_clr", 0, 0, 0, 8'h00, 1);
        chk("ovf_cleared", 32'(ovf_o), 32'd0);
        step("odrain1", 0, 1, 0, 8'h00, 0);
        step("odrain2", 0, 1, 0, 8'h00, 0);
        step("odrain3", 0, 1, 0, 8'h00, 0);

        // Underflow.
        step("unf_pop", 0, 1, 0, 8'h00, 0);
        chk("unf_flag", 32'(unf_o), 32'd1);
        step("unf_tos", 0, 0, 1, 8'h00, 0);
        chk("unf_dout_hold", 32'(dout_o), 32'h11);
        step("unf_pushpop", 1, 1, 0, 8'h9A, 0);
        chk("unf_pp_count", 32'(count_o), 32'd1);
        step("unf_pop2", 0, 1, 0, 8'h00, 0);
        chk("unf_pop2_val", 32'(dout_o), 32'h9A);
        // Error in the same cycle as clear: set wins.
        step("clr_setwins", 0, 1, 0, 8'h00, 1);
        chk("clr_setwins_unf", 32'(unf_o), 32'd1);
        step("clr_plain", 0, 0, 0, 8'h00, 1);

        // Replace and peek.
        step("rp1", 1, 0, 0, 8'h10, 0);
        step("rp2", 1, 0, 0, 8'h20, 0);
        step("rp_replace", 1, 1, 0, 8'h77, 0);
        chk("rp_replace_val", 32'(dout_o), 32'h20);
        step("rp_tos", 0, 0, 1, 8'h00, 0);
        chk("rp_tos_val", 32'(dout_o), 32'h77);
        step("rp_poptos", 0, 1, 1, 8'h00, 0);
        chk("rp_poptos_cnt", 32'(count_o), 32'd1);
        // push+tos sees the pre-push top
        step("pushtos", 1, 0, 1, 8'h5C, 0);
        chk("pushtos_val", 32'(dout_o), 32'h10);

        // High-water mark scenario from a fresh reset.
        do_reset("hwm_rst0");
        step("h_push1", 1, 0, 0, 8'h01, 0);
        step("h_push2", 1, 0, 0, 8'h02, 0);
        step("h_push3", 1, 0, 0, 8'h03, 0);
        step("h_pop1",  0, 1, 0, 8'h00, 0);
        step("h_pop2",  0, 1, 0, 8'h00, 0);
        step("h_push4", 1, 0, 0, 8'h04, 0);
`ifdef OPERAND_STACK_HWM_EN
        chk("hwm_is3", 32'(hwm_o), 32'd3);
`endif
        step("h_clr", 0, 0, 0, 8'h00, 1);
`ifdef OPERAND_STACK_HWM_EN
        chk("hwm_after_clr", 32'(hwm_o), 32'd3);
`endif
        do_reset("hwm_rst1");

        // Random commands against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(99) < 50),
                 ($urandom_range(99) < 40),
                 ($urandom_range(99) < 20),
                 WIDTH'($urandom),
                 ($urandom_range(99) < 10));
            if (i == 200) do_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
